product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/mult_pkg.sv | 17 +
 rtl/product_accumulator_beat_counter.sv | 59 +++++
 rtl/product_accumulator.sv | 117 +++++++++++
 tb/tb_product_accumulator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the product accumulation datapath.
//   PROD_W_DEF : width of one unsigned 4x4 array-multiplier product
//   ACC_W_DEF  : width of the group accumulator
//   CNT_W_DEF  : width of the group-length field (0 encodes 2^CNT_W)
//   state_t    : accumulator control states
package mult_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 10;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/product_accumulator_beat_counter.sv
// Beat counter for one product group.
// Loads on the first beat of a group, increments on later beats, and flags
// the beat that brings the count up to the latched group length.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   step       : a beat is accepted this cycle
//   clear      : group has been handed off; next beat starts a new group
//   grp_len    : requested group length (0 means 2^CNT_W), used on first beat only
//   cnt        : beats accepted so far in the current group
//   first      : next accepted beat opens a new group
//   close_hit  : the beat accepted this cycle reaches the group length
module beat_counter
  import mult_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             clear,
  input  logic [CNT_W-1:0] grp_len,
  output logic [CNT_W:0]   cnt,
  output logic             first,
  output logic             close_hit
);

  logic [CNT_W:0] cnt_reg;
  logic [CNT_W:0] len_reg;
  logic [CNT_W:0] len_decoded;
  logic [CNT_W:0] len_eff;
  logic [CNT_W:0] cnt_next;

  // A zero length field stands for the full 2^CNT_W beats.
  assign len_decoded = (grp_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, grp_len};

  // A count of zero marks "no beat yet in this group".
  assign first     = (cnt_reg == '0);
  // On the first beat the freshly sampled length applies; afterwards only
  // the latched one, so grp_len wiggles mid-group have no effect.
  assign len_eff   = first ? len_decoded : len_reg;
  assign cnt_next  = first ? {{CNT_W{1'b0}}, 1'b1} : cnt_reg + 1'b1;
  assign close_hit = (cnt_next == len_eff);
  assign cnt       = cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      len_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (step) begin
      cnt_reg <= cnt_next;
      if (first) begin
        len_reg <= len_decoded;
      end
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a stream of multiplier products into groups and emits one sum
// per group through a valid/ready handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : product beat handshake
//   product             : unsigned multiplier result
//   in_last             : closes the current group on this beat
//   grp_len             : beats per group, sampled on the group's first beat
//   out_valid/out_ready : group result handshake
//   sum                 : group sum modulo 2^ACC_W
//   overflow            : group sum exceeded 2^ACC_W-1
//   beats               : number of products in the emitted group
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              in_last,
  input  logic [CNT_W-1:0]  grp_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow,
  output logic [CNT_W:0]    beats
);

  state_t             state_reg;
  state_t             state_next;
  logic [ACC_W-1:0]   acc_reg;
  logic               ovf_reg;
  logic               accept;
  logic               take;
  logic               first;
  logic               close_hit;
  logic [CNT_W:0]     cnt;
  logic [ACC_W:0]     add_full;

  // Handshakes derived straight from the state register so the control
  // logic below has no combinational loop through in_ready/out_valid.
  assign accept = in_valid && (state_reg == ACCUM) && !rst;
  assign take   = out_ready && (state_reg == HOLD);

  // Extra top bit captures the carry-out of the modular accumulation.
  assign add_full = {1'b0, acc_reg} + (ACC_W + 1)'(product);

  beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk       (clk),
    .rst       (rst),
    .step      (accept),
    .clear     (take),
    .grp_len   (grp_len),
    .cnt       (cnt),
    .first     (first),
    .close_hit (close_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready = !rst;
        if (accept && (close_hit || in_last)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // No bypass: the next beat is taken in the cycle after the hand-off.
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (accept) begin
      if (first) begin
        acc_reg <= ACC_W'(product);
        ovf_reg <= 1'b0;
      end else begin
        acc_reg <= add_full[ACC_W-1:0];
        ovf_reg <= ovf_reg | add_full[ACC_W];
      end
    end
  end

  assign sum      = acc_reg;
  assign overflow = ovf_reg;
  assign beats    = cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios with
// literal expectations plus randomized traffic checked every cycle against
// a group-level reference model.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] product = '0;
  logic       in_last = 1'b0;
  logic [3:0] grp_len = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] sum;
  logic       overflow;
  logic [4:0] beats;

  int errors = 0;
  int checks = 0;

  product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .in_last   (in_last),
    .grp_len   (grp_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow),
    .beats     (beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (group level) ----------------
  bit m_hold = 1'b0;
  int m_items[$];
  int m_len = 0;
  int exp_sum = 0;
  int exp_ovf = 0;
  int exp_beats = 0;
  bit chk_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_hold = 1'b0;
        m_items.delete();
      end else if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0;
          m_items.delete();
        end
      end else if (in_valid) begin
        if (m_items.size() == 0) m_len = (grp_len == 0) ? 16 : int'(grp_len);
        m_items.push_back(int'(product));
        if (m_items.size() == m_len || in_last) begin
          int total;
          total = 0;
          foreach (m_items[k]) total += m_items[k];
          exp_sum   = total % 1024;
          exp_ovf   = (total > 1023) ? 1 : 0;
          exp_beats = m_items.size();
          m_hold    = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", int'(in_ready), (!rst && !m_hold) ? 1 : 0);
        chk("out_valid", int'(out_valid), m_hold ? 1 : 0);
        if (m_hold && out_valid) begin
          chk("sum", int'(sum), exp_sum);
          chk("overflow", int'(overflow), exp_ovf);
          chk("beats", int'(beats), exp_beats);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic beat(input int p, input bit last, input int len);
    bit ok;
    int n;
    in_valid = 1'b1;
    product  = 8'(p);
    in_last  = last;
    grp_len  = 4'(len);
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string name, input int s, input int b, input int o,
                            input int max_wait);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, max_wait);
    chk({name, "_sum"}, int'(sum), s);
    chk({name, "_beats"}, int'(beats), b);
    chk({name, "_ovf"}, int'(overflow), o);
    $display("group %s: sum=%0d beats=%0d overflow=%0d", name, sum, beats, overflow);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset and reset-state values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_beats", int'(beats), 0);
    chk("rst_in_ready_after", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Three back-to-back beats of 65
    for (int i = 0; i < 3; i++) beat(65, 1'b0, 3);
    expect_out("len3", 195, 3, 0, 0);

    // 16-beat group via length 0; 15 beats must not emit
    for (int i = 0; i < 15; i++) beat(1, 1'b0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("len16_no_early_out", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    beat(1, 1'b0, 0);
    expect_out("len16", 16, 16, 0, 0);

    // Overflow with early close via in_last
    for (int i = 0; i < 5; i++) beat(225, (i == 4), 8);
    expect_out("ovf", 101, 5, 1, 0);

    // Backpressure in HOLD
    beat(3, 1'b0, 2);
    beat(4, 1'b0, 2);
    in_valid = 1'b1;
    product  = 8'd9;
    grp_len  = 4'd1;
    repeat (4) begin
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_sum", int'(sum), 7);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_take_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("after_take_in_ready", int'(in_ready), 1);
    chk("after_take_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("next_group_sum", int'(sum), 9);
    chk("next_group_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset mid-group discards the partial sum
    beat(10, 1'b0, 3);
    beat(20, 1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_out", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    beat(42, 1'b0, 1);
    expect_out("single", 42, 1, 0, 0);

    // Length change after the first beat is ignored
    beat(5, 1'b0, 2);
    beat(6, 1'b0, 7);
    expect_out("lenchg", 11, 2, 0, 0);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      product   = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
      in_last   = ($urandom_range(0, 9) == 0);
      grp_len   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
